// File: rtl/huffman_pkg.sv
// Shared types and helpers for the Huffman packer: state encoding, latched
// code table entry, mask-to-length and raw-to-symbol mapping.
package huffman_pkg;

  localparam int SYM_W_DEF   = 3;
  localparam int MAX_SYM_DEF = 100;
  localparam int CODE_W      = 5;
  localparam int ACC_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT_CODE,
    S_ENCODE,
    S_FLUSH,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [2:0]        len;
  } code_entry_t;

  // Masks are contiguous low ones, so the popcount is the code length.
  function automatic logic [2:0] mask_len(input logic [CODE_W-1:0] m);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < CODE_W; i++) n = n + 3'(m[i]);
    return n;
  endfunction

  // 7 folds onto 6, matching the table builder's symbol alphabet.
  function automatic logic [2:0] sym_map(input logic [2:0] g);
    return (g[2:1] == 2'b11) ? 3'd6 : g;
  endfunction

endpackage

// File: rtl/huffman_sym_buf.sv
// Frame symbol store: one write port, one read port with a registered read.
module huffman_sym_buf #(
  parameter int DEPTH = 100,
  parameter int W     = 3,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/huffman_packer.sv
// Buffers a symbol frame, latches the builder's code table, then replays the
// frame through the table and emits an MSB-first bitstream as bytes.
module huffman_packer
  import huffman_pkg::*;
#(
  parameter int MAX_SYM = MAX_SYM_DEF,
  parameter int SYM_W   = SYM_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] gray_data,
  input  logic       code_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       done,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = $clog2(MAX_SYM);
  localparam int PW = $clog2(MAX_SYM + 1);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_SYM);
  localparam logic [PW-1:0] ONE_P = PW'(1);

  state_t state, state_nx;

  logic [CODE_W-1:0] hc_in [1:6];
  logic [CODE_W-1:0] m_in  [1:6];
  code_entry_t       tbl   [8];

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [ACC_W-1:0] acc, acc_sh, acc_nx, app_bits;
  logic [4:0]       acc_n, n_sh, n_nx, app_len;
  logic             sym_vld, last_formed;

  logic [SYM_W-1:0] sym_in, rd_data;
  logic [AW-1:0]    wr_addr;
  logic             sym_ok, cap, wr_en, issue, more, out_free, emit, flush_emit;
  code_entry_t      ent;

  logic unused;
  assign unused = ^{gray_data[7:3], HC1[7:5], HC2[7:5], HC3[7:5], HC4[7:5], HC5[7:5],
                    HC6[7:5], M1[7:5], M2[7:5], M3[7:5], M4[7:5], M5[7:5], M6[7:5]};

  assign hc_in = '{HC1[4:0], HC2[4:0], HC3[4:0], HC4[4:0], HC5[4:0], HC6[4:0]};
  assign m_in  = '{M1[4:0], M2[4:0], M3[4:0], M4[4:0], M5[4:0], M6[4:0]};

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);

  huffman_sym_buf #(.DEPTH(MAX_SYM), .W(SYM_W), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (sym_in),
    .rd_en   (issue),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  // Capture side
  always_comb begin
    sym_in  = SYM_W'(sym_map(gray_data[2:0]));
    sym_ok  = (sym_in != '0);
    cap     = in_valid && (state == S_IDLE || state == S_CAPTURE);
    wr_en   = cap && sym_ok && (state == S_IDLE || wr_ptr < MAX_P);
    wr_addr = (state == S_IDLE) ? '0 : wr_ptr[AW-1:0];
  end

  // Packer datapath. A byte holding exactly the last 8 bits is not formed in
  // ENCODE; FLUSH forms it so it can carry out_last when first presented.
  always_comb begin
    out_free   = !out_valid || out_ready;
    ent        = tbl[rd_data[2:0]];
    more       = sym_vld || (rd_ptr != wr_ptr);
    emit       = (state == S_ENCODE) && (acc_n > 5'd8) && out_free;
    flush_emit = (state == S_FLUSH) && !last_formed && (acc_n != 5'd0) && out_free;
    n_sh       = emit ? acc_n - 5'd8 : acc_n;
    acc_sh     = emit ? {acc[7:0], 8'h00} : acc;
    app_bits   = '0;
    app_len    = '0;
    if (sym_vld) begin
      app_bits = ({ent.code, 11'b0} << (3'd5 - ent.len)) >> n_sh;
      app_len  = {2'b00, ent.len};
    end
    acc_nx = acc_sh | app_bits;
    n_nx   = n_sh + app_len;
    // Fetch only if the word still has room for the fetched code next cycle.
    issue  = (state == S_ENCODE) && (rd_ptr != wr_ptr) && (n_nx <= 5'd11);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (in_valid) state_nx = S_CAPTURE;
      S_CAPTURE:   if (!in_valid) state_nx = S_WAIT_CODE;
      S_WAIT_CODE: if (code_valid) state_nx = (wr_ptr == '0) ? S_DONE : S_ENCODE;
      S_ENCODE:    if (!more && acc_n <= 5'd8) state_nx = S_FLUSH;
      S_FLUSH: begin
        if (last_formed) begin
          if (out_valid && out_ready) state_nx = S_DONE;
        end else if (acc_n == 5'd0) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      acc         <= '0;
      acc_n       <= '0;
      sym_vld     <= 1'b0;
      last_formed <= 1'b0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
      out_byte    <= '0;
      out_last    <= 1'b0;
      for (int i = 0; i < 8; i++) tbl[i] <= '0;
    end else begin
      sym_vld <= issue;
      if (issue) rd_ptr <= rd_ptr + ONE_P;

      if (state == S_IDLE && in_valid) begin
        wr_ptr   <= sym_ok ? ONE_P : '0;
        overflow <= 1'b0;
      end else if (state == S_CAPTURE && in_valid && sym_ok) begin
        if (wr_ptr < MAX_P) wr_ptr <= wr_ptr + ONE_P;
        else                overflow <= 1'b1;
      end

      if (state == S_WAIT_CODE && code_valid) begin
        for (int i = 1; i <= 6; i++)
          tbl[i] <= '{code: hc_in[i] & m_in[i], len: mask_len(m_in[i])};
        rd_ptr      <= '0;
        acc         <= '0;
        acc_n       <= '0;
        last_formed <= 1'b0;
      end else if (state == S_ENCODE) begin
        acc   <= acc_nx;
        acc_n <= n_nx;
      end else if (flush_emit) begin
        acc_n       <= '0;
        last_formed <= 1'b1;
      end

      if (emit || flush_emit) begin
        out_valid <= 1'b1;
        out_byte  <= acc[ACC_W-1:ACC_W-8];
        out_last  <= flush_emit;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_huffman_packer.sv
// Randomized bench for huffman_packer: frames are scored against a bit-queue
// model built straight from the symbol map and code table.
module tb_huffman_packer;

  logic       clk = 1'b0;
  logic       rst, in_valid, code_valid, out_ready;
  logic [7:0] gray_data;
  logic [7:0] hc [1:6];
  logic [7:0] m  [1:6];
  logic       out_valid, out_last, done, overflow, busy;
  logic [7:0] out_byte;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         syms[$];
  logic [7:0] exp_bytes[$];
  bit         exp_ovf;

  always #5 clk = ~clk;

  huffman_packer #(.MAX_SYM(100), .SYM_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray_data(gray_data),
    .code_valid(code_valid),
    .HC1(hc[1]), .HC2(hc[2]), .HC3(hc[3]), .HC4(hc[4]), .HC5(hc[5]), .HC6(hc[6]),
    .M1(m[1]), .M2(m[2]), .M3(m[3]), .M4(m[4]), .M5(m[5]), .M6(m[6]),
    .out_ready(out_ready), .out_valid(out_valid), .out_byte(out_byte),
    .out_last(out_last), .done(done), .overflow(overflow), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Code of given length, with junk in the ignored upper bits.
  task automatic set_code(input int s, input int len, input int code);
    int mask;
    mask  = (1 << len) - 1;
    hc[s] = 8'(($urandom_range(7) << 5) | (code & mask));
    m[s]  = 8'(($urandom_range(7) << 5) | mask);
  endtask

  task automatic rand_table();
    for (int s = 1; s <= 6; s++) set_code(s, $urandom_range(5), $urandom);
  endtask

  function automatic void build_model();
    bit         bits[$];
    int         stored;
    logic [7:0] v;
    stored = 0;
    exp_bytes.delete();
    exp_ovf = 0;
    foreach (syms[i]) begin
      int g, s, len;
      g = syms[i] & 7;
      if (g == 0) continue;
      s = (g >= 6) ? 6 : g;
      if (stored == 100) begin
        exp_ovf = 1;
        continue;
      end
      stored++;
      len = $countones(m[s][4:0]);
      for (int b = len - 1; b >= 0; b--) bits.push_back(hc[s][b]);
    end
    for (int i = 0; i < bits.size(); i += 8) begin
      v = '0;
      for (int k = 0; k < 8; k++) v = {v[6:0], (i + k < bits.size()) ? bits[i + k] : 1'b0};
      exp_bytes.push_back(v);
    end
  endfunction

  task automatic run_frame(input int stall_pct, input int stall_first, input bit do_reset,
                           input bit noise);
    int         got, cyc, hold_n;
    bit         held;
    logic [7:0] hb;
    build_model();
    got = 0; cyc = 0; hold_n = 0; held = 0; hb = '0;
    foreach (syms[i]) begin
      in_valid  = 1'b1;
      gray_data = 8'(syms[i]);
      tick();
      if (i == 0) check("busy_cap", 32'(busy), 32'd1);
    end
    in_valid = 1'b0; gray_data = '0;
    tick(); tick();
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    while (cyc < 4000) begin
      if (done) break;
      if (held) begin
        check("hold_vld", 32'(out_valid), 32'd1);
        check("hold_byte", 32'(out_byte), 32'(hb));
      end
      if (out_valid && got == 0 && hold_n < stall_first) begin
        out_ready = 1'b0;
        hold_n++;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      if (out_valid && out_ready) begin
        if (got < exp_bytes.size()) begin
          check("byte", 32'(out_byte), 32'(exp_bytes[got]));
          check("last", 32'(out_last), 32'(got == exp_bytes.size() - 1));
        end else begin
          check("extra_byte", 32'(out_byte), 32'hFFFF_FFFF);
        end
        got++;
      end
      held      = out_valid && !out_ready;
      hb        = out_byte;
      in_valid  = noise && ($urandom_range(1) == 1);
      gray_data = 8'($urandom_range(255));
      tick();
      cyc++;
      if (do_reset && got == 1) begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("rst_mid_vld", 32'(out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        return;
      end
    end
    if (cyc >= 4000) check("timeout", 32'd0, 32'd1);
    check("byte_count", 32'(got), 32'(exp_bytes.size()));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; code_valid = 1'b0; out_ready = 1'b0; gray_data = '0;
    for (int s = 1; s <= 6; s++) begin
      hc[s] = '0;
      m[s]  = '0;
    end
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // 1,1,1,2 with 1='0', 2='11'
    rand_table(); set_code(1, 1, 0); set_code(2, 2, 3);
    syms = '{1, 1, 1, 2};
    run_frame(0, 0, 0, 0);

    // eight '10' codes, then the same with a 3-cycle stall on the first byte
    rand_table(); set_code(3, 2, 2);
    syms.delete(); repeat (8) syms.push_back(3);
    run_frame(0, 0, 0, 0);
    run_frame(0, 3, 0, 0);

    // 101 symbols: one dropped, 100 bits of zero
    rand_table(); set_code(1, 1, 0);
    syms.delete(); repeat (101) syms.push_back(1);
    run_frame(20, 0, 0, 0);

    // zero skipped, 7 folded onto 6
    rand_table(); set_code(6, 2, 1); set_code(5, 3, 1);
    syms = '{0, 7, 5};
    run_frame(0, 0, 0, 0);

    // empty frame
    syms = '{0, 8, 0};
    run_frame(0, 0, 0, 0);

    // reset mid-encode, then a clean frame
    rand_table(); set_code(4, 5, 21);
    syms.delete(); repeat (60) syms.push_back(4);
    run_frame(0, 0, 1, 0);
    rand_table(); set_code(1, 1, 0); set_code(2, 2, 3);
    syms = '{1, 1, 1, 2};
    run_frame(0, 0, 0, 0);

    for (int f = 0; f < 8; f++) begin
      rand_table();
      syms.delete();
      repeat ($urandom_range(1, 110)) syms.push_back($urandom_range(255));
      run_frame($urandom_range(60), $urandom_range(3), 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/huffman_packer.md
Name: huffman_packer

Overview:
- Downstream stage of the Huffman table builder.
- Buffers the symbol stream during `in_valid` and latches the six code/mask pairs on the builder's `code_valid` pulse.
- Replays the buffered symbols through the table and emits an MSB-first packed bitstream as bytes over a valid/ready interface.
- Feeds the output formatter/storage stage.

Parameters:
- MAX_SYM, 100: symbol buffer depth; one frame holds at most this many symbols.
- SYM_W, 3: stored symbol width.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  symbol stream valid, same timing as the builder's input.
- gray_data  in  8  symbol; only [2:0] is used.
- code_valid  in  1  single-cycle pulse from the builder; tables are valid this cycle.
- HC1..HC6  in  8 each  code bits for symbols 1..6; [4:0] used.
- M1..M6  in  8 each  code masks for symbols 1..6; [4:0] used; contiguous low ones.
- out_ready  in  1  downstream accepts a byte.
- out_valid  out  1  out_byte is valid.
- out_byte  out  8  packed code bits; first bit in bit 7.
- out_last  out  1  marks the final byte of the frame.
- done  out  1  one-cycle pulse when the frame is fully sent.
- overflow  out  1  sticky: more than MAX_SYM symbols were offered this frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: synchronous, active-high, fixed; rst wins over all other inputs. State=IDLE; out_valid, out_byte, out_last, done, overflow, busy all 0; pointers, counters and accumulator cleared.
- Symbol map (matches the builder):
  - [2:1]=11 gives symbol 6, so 7 is folded into 6.
  - Values 1..5 map to themselves.
  - 0 is not a symbol: not stored and not counted.
- States: IDLE, CAPTURE, WAIT_CODE, ENCODE, FLUSH, DONE.
- IDLE:
  - in_valid=1 moves to CAPTURE; that same cycle's symbol is stored.
  - overflow is cleared on this transition.
- CAPTURE:
  - Each in_valid cycle stores the symbol at wr_ptr and increments wr_ptr.
  - At wr_ptr=MAX_SYM, further symbols are dropped and overflow is set.
  - in_valid=0 moves to WAIT_CODE.
- WAIT_CODE:
  - On code_valid, latch HCn[4:0] and len_n = popcount(Mn[4:0]) (0..5).
  - If wr_ptr=0, go directly to DONE with no bytes emitted.
  - Otherwise go to ENCODE with rd_ptr=0.
  - code_valid in any other state is ignored.
- ENCODE:
  - 16-bit accumulator acc plus 5-bit count acc_n.
  - Each cycle with acc_n<=11 and rd_ptr<wr_ptr: fetch one symbol, append its len code bits (bit len-1 first) below the current acc_n bits, advance rd_ptr.
  - A symbol with len 0 appends nothing.
  - When acc_n>=8 and the output register is free (out_valid=0, or out_valid & out_ready this cycle): load out_byte = top 8 bits, shift acc, acc_n -= 8.
  - When all symbols are fetched and acc_n<8, go to FLUSH.
- FLUSH:
  - If acc_n>0, emit one byte with the remaining bits left-aligned and zero-padded.
  - The frame's final byte carries out_last=1.
  - If acc_n=0, the last full byte (held or pending) is the one marked out_last.
- Handshake:
  - out_valid asserts one cycle after the byte is formed (registered).
  - out_byte and out_last hold stable while out_valid & !out_ready.
  - A transfer occurs when out_valid & out_ready.
  - Back-to-back bytes are allowed every cycle.
- DONE: reached after the out_last transfer (or from an empty frame). done=1 for one cycle, then IDLE.
- in_valid outside IDLE/CAPTURE is ignored; busy tells the source.
- Reset mid-frame: the frame is abandoned and no further bytes are emitted.
- Throughput: one symbol per cycle when downstream never stalls.

Decomposition:
- huffman_pkg holds: SYM_W, MAX_SYM default, CODE_W=5, state enum, a code_entry struct {code[4:0], len[2:0]}, and a mask-to-length function.
- One sub-module, huffman_sym_buf: MAX_SYM x SYM_W storage, 1 write port, 1 read port, registered read.
- The FSM, table latch and packer live in huffman_packer.

Test Plan:
- Codes 1='0'(HC1=0x00,M1=0x01) and 2='11'(HC2=0x03,M2=0x03); stream 1,1,1,2 -> one byte 0x18 with out_last=1, then done pulse.
- 8 symbols all '10' (len 2) -> bytes 0xAA, 0xAA; out_last only on the second byte.
- Same as previous with out_ready low for 3 cycles on the first byte -> out_byte=0xAA held stable, no loss, same final output.
- 101 symbols of value 1 with code '0' -> overflow=1; 100 bits, so 13 bytes of 0x00 with the last padded; out_last on byte 13.
- Stream 0,7,5 with 6='01', 5='001' -> 0 skipped, 7 coded as 6: bits 01001 -> 0x48 with out_last; the empty-frame case (all zeros) -> no bytes, done pulse.
- rst asserted in ENCODE after the first byte -> out_valid=0 the next cycle, IDLE; a following clean frame encodes correctly.
